calc_control_fsm: RTL and testbench
===================================

# calc_control_fsm

Sequencing controller for the keypad BCD calculator. Takes decoded key events and assembles two BCD operands and an operator. On '=', it drives the BCD add/subtract datapath through a fixed two-cycle `igual_en` window and captures the result. It also chooses the 16-bit BCD value presented to the 7-segment display driver.

## Interface
- DIGITS, 4, BCD digits per operand; operand/result width is 4*DIGITS; only 4 is supported with the current datapath
- clk  input  1  system clock, all state on rising edge
- reset_n  input  1  asynchronous active-low reset
- key_valid  input  1  one-cycle pulse, key_code valid this cycle
- key_code  input  4  0x0–0x9 digit, 0xA '+', 0xB '-', 0xC '=', 0xD clear, 0xE/0xF ignored
- resultado  input  16  BCD result from datapath
- operacion_valida  input  1  datapath valid flag (0 = overflow/invalid)
- numero_1  output  16  operand A to datapath
- numero_2  output  16  operand B to datapath
- suma_resta  output  2  2'b10 add, 2'b11 subtract, 2'b00 none
- igual_en  output  1  datapath execute enable
- display  output  16  BCD value for display driver
- error  output  1  last result invalid; display shows 16'hFFFF
- busy  output  1  high in EXEC and WAIT

## Operation
- State register: ENTER_A, ENTER_B, EXEC, WAIT, SHOW.
- Reset (async, reset_n=0):
  - state=ENTER_A
  - numero_1, numero_2, display = 0
  - suma_resta=2'b00
  - igual_en=0, error=0, busy=0
  - digit counter=0
- Digit entry (ENTER_A into numero_1, ENTER_B into numero_2):
  - operand <= {operand[11:0], digit}; counter++
  - When counter==DIGITS, further digits are ignored (no wrap, no shift).
- ENTER_A:
  - '+' or '-' sets suma_resta, clears counter and numero_2, goes to ENTER_B.
  - '=' is ignored.
- ENTER_B:
  - '+' or '-' with counter==0 replaces suma_resta; with counter>0 it is ignored.
  - '=' goes to EXEC. numero_2 may be 0 if no digits were entered.
- EXEC: igual_en=1, busy=1; unconditionally goes to WAIT.
- WAIT:
  - igual_en=1, busy=1
  - Captures resultado/operacion_valida at this state's closing edge, then goes to SHOW.
  - Capture: result_reg <= resultado; error <= ~operacion_valida.
- SHOW:
  - A digit clears numero_1, numero_2, error and the counter, loads the digit into numero_1, and goes to ENTER_A.
  - '+' or '-': see Configuration.
  - '=' is ignored.
- Clear (0xD), accepted in any state:
  - Next state ENTER_A; operands, result, error, counter and suma_resta are zeroed; igual_en drops next cycle.
  - In EXEC or WAIT this aborts without capturing.
- All non-clear keys in EXEC or WAIT are dropped (no queueing).
- display:
  - ENTER_A: numero_1
  - ENTER_B: numero_2 if counter>0, else numero_1
  - EXEC/WAIT: holds the previous value
  - SHOW: result_reg, or 16'hFFFF when error=1
- All outputs are registered. No combinational path from key inputs to outputs.

## Timing
- A key pulsed in cycle N updates state and operands at edge N+1, visible in cycle N+1.
- '=' at cycle N:
  - EXEC in N+1 (igual_en=1)
  - datapath registers at edge N+2
  - WAIT in N+2 (igual_en=1)
  - capture at edge N+3; SHOW and display valid in N+3
- igual_en is high for exactly 2 consecutive cycles per operation. numero_1, numero_2 and suma_resta are stable from N+1 through N+2.
- key_valid held high for several cycles is treated as one key per cycle. The upstream keypad scanner guarantees single pulses.
- reset_n asserted mid-operation clears everything immediately. The first key is accepted at the first edge after deassertion.

## Configuration
- CALC_CHAIN_EN defined:
  - In SHOW with error=0, '+' or '-' copies result_reg into numero_1, sets suma_resta, clears numero_2 and the counter, and goes to ENTER_B.
  - With error=1, the operator is ignored.
- CALC_CHAIN_EN undefined: '+' or '-' in SHOW is ignored; only a digit or clear leaves SHOW.

## Test plan
- Reset, then keys 1,2,3,+,4,5,= → numero_1=0x0123, numero_2=0x0045, suma_resta=2'b10, igual_en high exactly 2 cycles, display=0x0168 in SHOW, error=0.
- Keys 1,2,3,4,5 → numero_1=0x1234, 5th digit ignored; then '-', '+' → suma_resta=2'b10 (replacement with no B digits).
- Keys 9,9,9,9,+,1,= with datapath reporting operacion_valida=0 → error=1, display=0xFFFF; then '+' → stays in SHOW.
- Clear pulsed in the WAIT cycle → next cycle state ENTER_A, igual_en=0, display=0, result not captured.
- With CALC_CHAIN_EN: 5,+,3,= then -,2,= → second operation numero_1=0x0008, numero_2=0x0002, suma_resta=2'b11, display=0x0006. Without the macro, the '-' is ignored and the '2' starts a new numero_1=0x0002.
- reset_n pulled low during EXEC → all outputs 0 asynchronously, igual_en=0 before the next edge.

Source files
------------

// File: rtl/calc_control_fsm.sv
// Keypad BCD calculator sequencer: collects two BCD operands and an operator,
// runs the datapath for a two-cycle execute window and selects the display value.
// Optional build macro CALC_CHAIN_EN: an operator in SHOW chains the last result as operand A.
module calc_control_fsm #(
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  key_valid,
  input  logic [3:0]            key_code,
  input  logic [4*DIGITS-1:0]   resultado,
  input  logic                  operacion_valida,
  output logic [4*DIGITS-1:0]   numero_1,
  output logic [4*DIGITS-1:0]   numero_2,
  output logic [1:0]            suma_resta,
  output logic                  igual_en,
  output logic [4*DIGITS-1:0]   display,
  output logic                  error,
  output logic                  busy
);

  localparam int W  = 4 * DIGITS;
  localparam int CW = $clog2(DIGITS + 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(DIGITS);

  typedef enum logic [2:0] {
    ST_ENTER_A,
    ST_ENTER_B,
    ST_EXEC,
    ST_WAIT,
    ST_SHOW
  } state_t;

  state_t          r_state;
  logic [W-1:0]    r_num1;
  logic [W-1:0]    r_num2;
  logic [W-1:0]    r_result;
  logic [W-1:0]    r_display;
  logic [CW-1:0]   r_cnt;
  logic [1:0]      r_op;
  logic            r_igual;
  logic            r_busy;
  logic            r_error;

  logic            w_digit;
  logic            w_oper;
  logic            w_equal;
  logic            w_clear;
  logic            w_full;
  logic [1:0]      w_op_code;
  logic [W-1:0]    w_digit_ext;

  // Key decode; 0xE/0xF fall through every class and are dropped.
  assign w_digit     = key_valid && (key_code <= 4'h9);
  assign w_oper      = key_valid && ((key_code == 4'hA) || (key_code == 4'hB));
  assign w_equal     = key_valid && (key_code == 4'hC);
  assign w_clear     = key_valid && (key_code == 4'hD);
  assign w_full      = (r_cnt == CNT_FULL);
  assign w_op_code   = {1'b1, key_code[0]};
  assign w_digit_ext = {{(W-4){1'b0}}, key_code};

  // NOTE: all state below lives in one clocked block with non-blocking updates, so
  // every right-hand side reads the pre-edge value regardless of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= ST_ENTER_A;
      r_num1    <= '0;
      r_num2    <= '0;
      r_result  <= '0;
      r_display <= '0;
      r_cnt     <= '0;
      r_op      <= 2'b00;
      r_igual   <= 1'b0;
      r_busy    <= 1'b0;
      r_error   <= 1'b0;
    end else if (w_clear) begin
      // Clear wins in every state, including an in-flight EXEC/WAIT (no capture).
      r_state   <= ST_ENTER_A;
      r_num1    <= '0;
      r_num2    <= '0;
      r_result  <= '0;
      r_display <= '0;
      r_cnt     <= '0;
      r_op      <= 2'b00;
      r_igual   <= 1'b0;
      r_busy    <= 1'b0;
      r_error   <= 1'b0;
    end else begin
      unique case (r_state)
        ST_ENTER_A: begin
          if (w_digit && !w_full) begin
            r_num1    <= {r_num1[W-5:0], key_code};
            r_display <= {r_num1[W-5:0], key_code};
            r_cnt     <= r_cnt + 1'b1;
          end else if (w_oper) begin
            r_op      <= w_op_code;
            r_num2    <= '0;
            r_cnt     <= '0;
            r_display <= r_num1;
            r_state   <= ST_ENTER_B;
          end
        end

        ST_ENTER_B: begin
          if (w_digit && !w_full) begin
            r_num2    <= {r_num2[W-5:0], key_code};
            r_display <= {r_num2[W-5:0], key_code};
            r_cnt     <= r_cnt + 1'b1;
          end else if (w_oper && (r_cnt == '0)) begin
            r_op <= w_op_code;
          end else if (w_equal) begin
            r_igual <= 1'b1;
            r_busy  <= 1'b1;
            r_state <= ST_EXEC;
          end
        end

        ST_EXEC: begin
          r_state <= ST_WAIT;
        end

        ST_WAIT: begin
          r_result  <= resultado;
          r_error   <= ~operacion_valida;
          r_display <= operacion_valida ? resultado : '1;
          r_igual   <= 1'b0;
          r_busy    <= 1'b0;
          r_state   <= ST_SHOW;
        end

        ST_SHOW: begin
          if (w_digit) begin
            // The loaded digit counts as the first digit of the new operand.
            r_num1    <= w_digit_ext;
            r_num2    <= '0;
            r_error   <= 1'b0;
            r_cnt     <= CW'(1);
            r_display <= w_digit_ext;
            r_state   <= ST_ENTER_A;
          end
`ifdef CALC_CHAIN_EN
          else if (w_oper && !r_error) begin
            r_num1    <= r_result;
            r_num2    <= '0;
            r_op      <= w_op_code;
            r_cnt     <= '0;
            r_display <= r_result;
            r_state   <= ST_ENTER_B;
          end
`endif
        end

        default: r_state <= ST_ENTER_A;
      endcase
    end
  end

  assign numero_1   = r_num1;
  assign numero_2   = r_num2;
  assign suma_resta = r_op;
  assign igual_en   = r_igual;
  assign display    = r_display;
  assign error      = r_error;
  assign busy       = r_busy;

endmodule

// File: tb/tb_calc_control_fsm.sv
// Bench for calc_control_fsm: behavioural calculator model compared every cycle,
// plus directed key sequences with literal expectations.
module tb_calc_control_fsm;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        key_valid;
  logic [3:0]  key_code;
  logic [15:0] resultado;
  logic        operacion_valida;
  logic [15:0] numero_1;
  logic [15:0] numero_2;
  logic [1:0]  suma_resta;
  logic        igual_en;
  logic [15:0] display;
  logic        error;
  logic        busy;

  int n_checks = 0;
  int n_errors = 0;
  bit cmp_en   = 1'b0;

  calc_control_fsm #(.DIGITS(4)) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .key_valid        (key_valid),
    .key_code         (key_code),
    .resultado        (resultado),
    .operacion_valida (operacion_valida),
    .numero_1         (numero_1),
    .numero_2         (numero_2),
    .suma_resta       (suma_resta),
    .igual_en         (igual_en),
    .display          (display),
    .error            (error),
    .busy             (busy)
  );

  always #5 clk = ~clk;

  function automatic int bcd2int(input logic [15:0] v);
    return int'(v[15:12]) * 1000 + int'(v[11:8]) * 100 + int'(v[7:4]) * 10 + int'(v[3:0]);
  endfunction

  function automatic logic [15:0] int2bcd(input int v);
    logic [15:0] r;
    r[15:12] = 4'((v / 1000) % 10);
    r[11:8]  = 4'((v / 100) % 10);
    r[7:4]   = 4'((v / 10) % 10);
    r[3:0]   = 4'(v % 10);
    return r;
  endfunction

  // Stand-in BCD add/subtract datapath: registers its result while igual_en is high.
  initial begin
    resultado        = 16'h0000;
    operacion_valida = 1'b1;
  end
  always @(posedge clk) begin
    int a, b, s;
    if (igual_en) begin
      a = bcd2int(numero_1);
      b = bcd2int(numero_2);
      if (suma_resta == 2'b11) begin
        s = a - b;
        operacion_valida <= (s >= 0);
        resultado        <= (s >= 0) ? int2bcd(s) : 16'h0000;
      end else begin
        s = a + b;
        operacion_valida <= (s <= 9999);
        resultado        <= (s <= 9999) ? int2bcd(s) : 16'h0000;
      end
    end
  end

  // Behavioural model: calculator mode, operands as integers of up to four digits.
  typedef enum {M_A, M_B, M_RUN, M_SHOW} mode_t;
  mode_t       m_mode;
  int          m_a, m_b, m_ndig, m_run_left, m_res;
  bit          m_sub, m_has_op, m_err;
  logic [15:0] m_disp;

  always @(posedge clk or negedge reset_n) begin
    int k, s;
    if (!reset_n) begin
      m_mode = M_A; m_a = 0; m_b = 0; m_ndig = 0; m_run_left = 0; m_res = 0;
      m_sub = 0; m_has_op = 0; m_err = 0; m_disp = 16'h0000;
    end else begin
      k = key_valid ? int'(key_code) : -1;
      if (k == 13) begin
        m_mode = M_A; m_a = 0; m_b = 0; m_ndig = 0; m_res = 0;
        m_sub = 0; m_has_op = 0; m_err = 0;
      end else begin
        case (m_mode)
          M_A: begin
            if (k >= 0 && k <= 9 && m_ndig < 4) begin
              m_a = m_a * 10 + k; m_ndig++;
            end else if (k == 10 || k == 11) begin
              m_sub = (k == 11); m_has_op = 1; m_b = 0; m_ndig = 0; m_mode = M_B;
            end
          end
          M_B: begin
            if (k >= 0 && k <= 9 && m_ndig < 4) begin
              m_b = m_b * 10 + k; m_ndig++;
            end else if ((k == 10 || k == 11) && m_ndig == 0) begin
              m_sub = (k == 11);
            end else if (k == 12) begin
              m_mode = M_RUN; m_run_left = 2;
            end
          end
          M_RUN: begin
            m_run_left--;
            if (m_run_left == 0) begin
              s     = m_sub ? m_a - m_b : m_a + m_b;
              m_err = (s < 0) || (s > 9999);
              m_res = m_err ? 0 : s;
              m_mode = M_SHOW;
            end
          end
          M_SHOW: begin
            if (k >= 0 && k <= 9) begin
              m_a = k; m_b = 0; m_err = 0; m_ndig = 1; m_mode = M_A;
            end
`ifdef CALC_CHAIN_EN
            else if ((k == 10 || k == 11) && !m_err) begin
              m_a = m_res; m_b = 0; m_sub = (k == 11); m_has_op = 1; m_ndig = 0; m_mode = M_B;
            end
`endif
          end
          default: ;
        endcase
      end
      case (m_mode)
        M_A:     m_disp = int2bcd(m_a);
        M_B:     m_disp = (m_ndig > 0) ? int2bcd(m_b) : int2bcd(m_a);
        M_SHOW:  m_disp = m_err ? 16'hFFFF : int2bcd(m_res);
        default: ;
      endcase
    end
  end

  task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (cmp_en && reset_n) begin
      check("m_numero_1",   numero_1, int2bcd(m_a));
      check("m_numero_2",   numero_2, int2bcd(m_b));
      check("m_suma_resta", {14'd0, suma_resta}, m_has_op ? {14'd0, 1'b1, m_sub} : 16'd0);
      check("m_igual_en",   {15'd0, igual_en}, {15'd0, m_mode == M_RUN});
      check("m_busy",       {15'd0, busy},     {15'd0, m_mode == M_RUN});
      check("m_error",      {15'd0, error},    {15'd0, m_err});
      check("m_display",    display, m_disp);
    end
  end

  // Inputs change 1 time unit after the rising edge; tasks return at that point.
  task automatic press(input logic [3:0] c);
    key_valid = 1'b1;
    key_code  = c;
    @(posedge clk); #1;
    key_valid = 1'b0;
    key_code  = 4'h0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic press_seq(input logic [3:0] seq[]);
    foreach (seq[i]) press(seq[i]);
  endtask

  initial begin
    reset_n   = 1'b0;
    key_valid = 1'b0;
    key_code  = 4'h0;
    idle(2);
    check("rst_numero_1", numero_1, 16'h0000);
    check("rst_display",  display,  16'h0000);
    check("rst_igual_en", {15'd0, igual_en}, 16'd0);
    check("rst_suma_resta", {14'd0, suma_resta}, 16'd0);
    @(negedge clk); #1;
    reset_n = 1'b1;
    cmp_en  = 1'b1;
    idle(1);

    // 123 + 45 = 168, igual_en window of exactly two cycles
    press_seq('{4'h1, 4'h2, 4'h3, 4'hA, 4'h4, 4'h5, 4'hC});
    check("t1_exec_igual", {15'd0, igual_en}, 16'd1);
    check("t1_numero_1",   numero_1, 16'h0123);
    check("t1_numero_2",   numero_2, 16'h0045);
    check("t1_suma_resta", {14'd0, suma_resta}, 16'd2);
    idle(1);
    check("t1_wait_igual", {15'd0, igual_en}, 16'd1);
    check("t1_wait_busy",  {15'd0, busy}, 16'd1);
    idle(1);
    check("t1_show_igual", {15'd0, igual_en}, 16'd0);
    check("t1_display",    display, 16'h0168);
    check("t1_error",      {15'd0, error}, 16'd0);

    // Fifth digit ignored; operator replaced while B has no digits; 0xE ignored
    press(4'hD);
    press_seq('{4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'hE});
    check("t2_numero_1", numero_1, 16'h1234);
    press(4'hB);
    check("t2_sub", {14'd0, suma_resta}, 16'd3);
    press(4'hA);
    check("t2_add", {14'd0, suma_resta}, 16'd2);
    check("t2_display", display, 16'h1234);
    press_seq('{4'h7, 4'hB});
    check("t2_op_locked", {14'd0, suma_resta}, 16'd2);
    check("t2_display_b", display, 16'h0007);

    // 9999 + 1 overflows
    press(4'hD);
    press_seq('{4'h9, 4'h9, 4'h9, 4'h9, 4'hA, 4'h1, 4'hC});
    idle(2);
    check("t3_error",   {15'd0, error}, 16'd1);
    check("t3_display", display, 16'hFFFF);
    press(4'hA);
    check("t3_stay_display", display, 16'hFFFF);
    check("t3_stay_num1",    numero_1, 16'h9999);
    press(4'hC);
    check("t3_eq_ignored", {15'd0, igual_en}, 16'd0);

    // Clear during WAIT aborts without capture
    press(4'hD);
    press_seq('{4'h1, 4'hA, 4'h2, 4'hC});
    idle(1);
    check("t4_in_wait", {15'd0, igual_en}, 16'd1);
    press(4'hD);
    check("t4_igual_en", {15'd0, igual_en}, 16'd0);
    check("t4_display",  display, 16'h0000);
    check("t4_error",    {15'd0, error}, 16'd0);
    press(4'h3);
    check("t4_new_entry", display, 16'h0003);

    // 5 + 3 = 8, then '-' '2' '='
    press(4'hD);
    press_seq('{4'h5, 4'hA, 4'h3, 4'hC});
    idle(2);
    check("t5_first", display, 16'h0008);
    press_seq('{4'hB, 4'h2});
`ifdef CALC_CHAIN_EN
    press(4'hC);
    check("t5_chain_num1", numero_1, 16'h0008);
    check("t5_chain_num2", numero_2, 16'h0002);
    check("t5_chain_op",   {14'd0, suma_resta}, 16'd3);
    idle(2);
    check("t5_chain_display", display, 16'h0006);
`else
    check("t5_nochain_num1", numero_1, 16'h0002);
    check("t5_nochain_num2", numero_2, 16'h0000);
    check("t5_nochain_disp", display, 16'h0002);
    press(4'hC);
    check("t5_nochain_eq", {15'd0, igual_en}, 16'd0);
`endif

    // Asynchronous reset in EXEC
    press(4'hD);
    press_seq('{4'h1, 4'hA, 4'h1, 4'hC});
    check("t6_exec", {15'd0, igual_en}, 16'd1);
    #2 reset_n = 1'b0;
    #1;
    check("t6_igual_en", {15'd0, igual_en}, 16'd0);
    check("t6_busy",     {15'd0, busy}, 16'd0);
    check("t6_numero_1", numero_1, 16'h0000);
    check("t6_numero_2", numero_2, 16'h0000);
    check("t6_display",  display, 16'h0000);
    check("t6_op",       {14'd0, suma_resta}, 16'd0);
    @(negedge clk); #1;
    reset_n = 1'b1;
    idle(1);
    press(4'h4);
    check("t6_first_key", numero_1, 16'h0004);
    idle(2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
